// File: rtl/router_fsm.sv
// -----------------------------------------------------------------------------
// router_fsm
//
// Control FSM of the 1-input / 3-output packet router. It decodes the 2-bit
// destination address from the header byte and sequences the header, payload,
// parity and full-stall loading into the selected output FIFO. It drives the
// strobes used by the router register block and the busy flag seen by the
// packet source.
//
// Ports
//   clk            in   system clock, all logic on the rising edge
//   rst            in   synchronous, active-high reset
//   soft_rst_0..2  in   per-output soft reset (reader timeout) from the
//                       synchronizer; honoured only for the latched address
//   pkt_valid      in   high while header/payload bytes are driven, falls
//                       when the parity byte is presented
//   fifo_full      in   full flag of the currently selected FIFO
//   fifo_empty_0..2 in  empty flags of the three output FIFOs
//   parity_done    in   parity byte already captured by the register block
//   low_pkt_valid  in   pkt_valid fell while the FSM was stalled on full
//   d_in[1:0]      in   address field, header byte bits [1:0]
//   detect_add     out  high in DECODE_ADDRESS
//   lfd_state      out  high in LOAD_FIRST_DATA
//   ld_state       out  high in LOAD_DATA
//   laf_state      out  high in LOAD_AFTER_FULL
//   full_state     out  high in FIFO_FULL_STATE
//   rst_int_reg    out  high in CHECK_PARITY_ERROR
//   wr_en_reg      out  high in LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL
//   busy           out  high in every state except DECODE_ADDRESS, LOAD_DATA
//
// Optional feature (macro ROUTER_FSM_STATE_DBG_EN)
//   state_dbg[2:0] out  raw state register, same encoding as the localparams
//   When the macro is undefined the port is absent; behaviour is unchanged.
//
// All outputs are a pure decode of the state register (Moore machine), so any
// input change is seen on the outputs one clock later.
// -----------------------------------------------------------------------------

module router_fsm (
   input  logic       clk,
   input  logic       rst,
   input  logic       soft_rst_0,
   input  logic       soft_rst_1,
   input  logic       soft_rst_2,
   input  logic       pkt_valid,
   input  logic       fifo_full,
   input  logic       fifo_empty_0,
   input  logic       fifo_empty_1,
   input  logic       fifo_empty_2,
   input  logic       parity_done,
   input  logic       low_pkt_valid,
   input  logic [1:0] d_in,
   output logic       detect_add,
   output logic       lfd_state,
   output logic       ld_state,
   output logic       laf_state,
   output logic       full_state,
   output logic       rst_int_reg,
   output logic       wr_en_reg,
   output logic       busy
`ifdef ROUTER_FSM_STATE_DBG_EN
   ,
   output logic [2:0] state_dbg
`endif
);

   // State encoding; all eight codes are legal states.
   localparam logic [2:0] DECODE_ADDRESS     = 3'd0;
   localparam logic [2:0] LOAD_FIRST_DATA    = 3'd1;
   localparam logic [2:0] LOAD_DATA          = 3'd2;
   localparam logic [2:0] LOAD_PARITY        = 3'd3;
   localparam logic [2:0] CHECK_PARITY_ERROR = 3'd4;
   localparam logic [2:0] FIFO_FULL_STATE    = 3'd5;
   localparam logic [2:0] LOAD_AFTER_FULL    = 3'd6;
   localparam logic [2:0] WAIT_TILL_EMPTY    = 3'd7;

   logic [2:0] r_state;
   logic [2:0] w_next_state;
   logic [1:0] r_addr;

   logic       w_soft_hit;     // soft reset on the port this packet targets
   logic       w_addr_empty;   // empty flag of the latched address
   logic       w_din_empty;    // empty flag of the address on d_in
   logic       w_din_legal;    // d_in is one of the three real ports

   // ---------------------------------------------------------------------------
   // Address selection helpers
   // ---------------------------------------------------------------------------

   // Only the soft reset of the currently latched output may abort the FSM.
   // An address of 3 never leaves DECODE_ADDRESS, so it has no soft reset.
   always_comb begin
      w_soft_hit = 1'b0;
      case (r_addr)
         2'd0:    w_soft_hit = soft_rst_0;
         2'd1:    w_soft_hit = soft_rst_1;
         2'd2:    w_soft_hit = soft_rst_2;
         default: w_soft_hit = 1'b0;
      endcase
   end

   // WAIT_TILL_EMPTY watches the latched address, not d_in, because the
   // source may already have moved on from the header byte.
   always_comb begin
      w_addr_empty = 1'b0;
      case (r_addr)
         2'd0:    w_addr_empty = fifo_empty_0;
         2'd1:    w_addr_empty = fifo_empty_1;
         2'd2:    w_addr_empty = fifo_empty_2;
         default: w_addr_empty = 1'b0;
      endcase
   end

   // DECODE_ADDRESS decides on the header byte currently on d_in.
   always_comb begin
      w_din_empty = 1'b0;
      w_din_legal = 1'b1;
      case (d_in)
         2'd0:    w_din_empty = fifo_empty_0;
         2'd1:    w_din_empty = fifo_empty_1;
         2'd2:    w_din_empty = fifo_empty_2;
         default: begin
            w_din_empty = 1'b0;
            w_din_legal = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      if (w_soft_hit) begin
         w_next_state = DECODE_ADDRESS;
      end else begin
         case (r_state)
            DECODE_ADDRESS: begin
               // Invalid address 3 keeps the FSM parked here.
               if (pkt_valid && w_din_legal) begin
                  if (w_din_empty)
                     w_next_state = LOAD_FIRST_DATA;
                  else
                     w_next_state = WAIT_TILL_EMPTY;
               end
            end

            LOAD_FIRST_DATA: begin
               w_next_state = LOAD_DATA;
            end

            LOAD_DATA: begin
               // A full FIFO must stall the write before end-of-packet is
               // considered, otherwise the last payload byte would be lost.
               if (fifo_full)
                  w_next_state = FIFO_FULL_STATE;
               else if (!pkt_valid)
                  w_next_state = LOAD_PARITY;
               else
                  w_next_state = LOAD_DATA;
            end

            FIFO_FULL_STATE: begin
               if (!fifo_full)
                  w_next_state = LOAD_AFTER_FULL;
            end

            LOAD_AFTER_FULL: begin
               // The byte held during the stall is written here; what follows
               // depends on how far the packet got while we were stalled.
               if (parity_done)
                  w_next_state = DECODE_ADDRESS;
               else if (low_pkt_valid)
                  w_next_state = LOAD_PARITY;
               else
                  w_next_state = LOAD_DATA;
            end

            LOAD_PARITY: begin
               w_next_state = CHECK_PARITY_ERROR;
            end

            CHECK_PARITY_ERROR: begin
               // Parity was written into a FIFO that then filled; hold off
               // until it drains so the write is not dropped.
               if (fifo_full)
                  w_next_state = FIFO_FULL_STATE;
               else
                  w_next_state = DECODE_ADDRESS;
            end

            WAIT_TILL_EMPTY: begin
               if (w_addr_empty)
                  w_next_state = LOAD_FIRST_DATA;
            end

            default: begin
               w_next_state = DECODE_ADDRESS;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // State and address registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= DECODE_ADDRESS;
      end else begin
         r_state <= w_next_state;
      end
   end

   // The address tracks d_in for as long as the FSM sits in DECODE_ADDRESS,
   // so it holds the header's address once the packet is accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr <= 2'd0;
      end else if (r_state == DECODE_ADDRESS) begin
         r_addr <= d_in;
      end
   end

   // ---------------------------------------------------------------------------
   // Moore output decode
   // ---------------------------------------------------------------------------
   always_comb begin
      detect_add  = (r_state == DECODE_ADDRESS);
      lfd_state   = (r_state == LOAD_FIRST_DATA);
      ld_state    = (r_state == LOAD_DATA);
      laf_state   = (r_state == LOAD_AFTER_FULL);
      full_state  = (r_state == FIFO_FULL_STATE);
      rst_int_reg = (r_state == CHECK_PARITY_ERROR);
      wr_en_reg   = (r_state == LOAD_DATA)   ||
                    (r_state == LOAD_PARITY) ||
                    (r_state == LOAD_AFTER_FULL);
      // The source may only push bytes while we are idle or streaming payload.
      busy        = !((r_state == DECODE_ADDRESS) || (r_state == LOAD_DATA));
   end

`ifdef ROUTER_FSM_STATE_DBG_EN
   assign state_dbg = r_state;
`endif

endmodule

// File: tb/tb_router_fsm.sv
// -----------------------------------------------------------------------------
// tb_router_fsm
//
// Directed bench for router_fsm. Inputs change 1 time unit after the rising
// edge; outputs are sampled at that same point, i.e. they reflect the state
// entered on that edge. Output vectors are packed as
// {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
//  wr_en_reg, busy}.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_router_fsm;

   // Hand-derived output vectors for each state.
   localparam logic [7:0] V_DA  = 8'b1000_0000;
   localparam logic [7:0] V_LFD = 8'b0100_0001;
   localparam logic [7:0] V_LD  = 8'b0010_0010;
   localparam logic [7:0] V_LP  = 8'b0000_0011;
   localparam logic [7:0] V_CPE = 8'b0000_0101;
   localparam logic [7:0] V_FFS = 8'b0000_1001;
   localparam logic [7:0] V_LAF = 8'b0001_0011;
   localparam logic [7:0] V_WTE = 8'b0000_0001;

   logic       clk = 1'b0;
   logic       rst;
   logic       soft_rst_0, soft_rst_1, soft_rst_2;
   logic       pkt_valid, fifo_full;
   logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
   logic       parity_done, low_pkt_valid;
   logic [1:0] d_in;
   logic       detect_add, lfd_state, ld_state, laf_state;
   logic       full_state, rst_int_reg, wr_en_reg, busy;
`ifdef ROUTER_FSM_STATE_DBG_EN
   logic [2:0] state_dbg;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   router_fsm dut (
      .clk           (clk),
      .rst           (rst),
      .soft_rst_0    (soft_rst_0),
      .soft_rst_1    (soft_rst_1),
      .soft_rst_2    (soft_rst_2),
      .pkt_valid     (pkt_valid),
      .fifo_full     (fifo_full),
      .fifo_empty_0  (fifo_empty_0),
      .fifo_empty_1  (fifo_empty_1),
      .fifo_empty_2  (fifo_empty_2),
      .parity_done   (parity_done),
      .low_pkt_valid (low_pkt_valid),
      .d_in          (d_in),
      .detect_add    (detect_add),
      .lfd_state     (lfd_state),
      .ld_state      (ld_state),
      .laf_state     (laf_state),
      .full_state    (full_state),
      .rst_int_reg   (rst_int_reg),
      .wr_en_reg     (wr_en_reg),
      .busy          (busy)
`ifdef ROUTER_FSM_STATE_DBG_EN
      ,
      .state_dbg     (state_dbg)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] exp);
      logic [7:0] obs;
      obs = {detect_add, lfd_state, ld_state, laf_state,
             full_state, rst_int_reg, wr_en_reg, busy};
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      soft_rst_0 = 1'b0; soft_rst_1 = 1'b0; soft_rst_2 = 1'b0;
      pkt_valid = 1'b1;  fifo_full = 1'b0;
      fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
      parity_done = 1'b0; low_pkt_valid = 1'b0;
      d_in = 2'd3;

      // Reset wins over everything, including the address load.
      step();
      chk("reset_outputs", V_DA);
      checks++;
      assert (dut.r_addr === 2'd0) else begin
         errors++;
         $error("FAIL reset_addr: observed=%0d expected=0", dut.r_addr);
      end
      rst = 1'b0;

      // Normal packet to FIFO0.
      d_in = 2'd0; pkt_valid = 1'b1;
      step(); chk("p0_lfd", V_LFD);
      pkt_valid = 1'b0;
      step(); chk("p0_ld", V_LD);
      step(); chk("p0_lp", V_LP);
      step(); chk("p0_cpe", V_CPE);
      step(); chk("p0_da", V_DA);

      // Busy destination FIFO1, then it drains.
      d_in = 2'd1; pkt_valid = 1'b1; fifo_empty_1 = 1'b0;
      step(); chk("wte_enter", V_WTE);
      step(); chk("wte_hold", V_WTE);
      fifo_empty_1 = 1'b1;
      step(); chk("wte_to_lfd", V_LFD);
      step(); chk("p1_ld", V_LD);
      step(); chk("p1_ld_stay", V_LD);

      // Full stall, recover into LD.
      fifo_full = 1'b1;
      step(); chk("ffs_enter", V_FFS);
      step(); chk("ffs_hold", V_FFS);
      fifo_full = 1'b0;
      step(); chk("laf_enter", V_LAF);
      step(); chk("laf_to_ld", V_LD);

      // Full stall, recover into LP via low_pkt_valid.
      fifo_full = 1'b1;
      step(); chk("ffs2", V_FFS);
      fifo_full = 1'b0;
      step(); chk("laf2", V_LAF);
      low_pkt_valid = 1'b1; pkt_valid = 1'b0;
      step(); chk("laf_to_lp", V_LP);
      low_pkt_valid = 1'b0;
      step(); chk("lp_to_cpe", V_CPE);
      step(); chk("cpe_to_da", V_DA);

      // Full stall, parity already taken -> straight back to decode.
      d_in = 2'd1; pkt_valid = 1'b1;
      step(); chk("p1b_lfd", V_LFD);
      step(); chk("p1b_ld", V_LD);
      fifo_full = 1'b1;
      step(); chk("p1b_ffs", V_FFS);
      fifo_full = 1'b0;
      step(); chk("p1b_laf", V_LAF);
      parity_done = 1'b1; pkt_valid = 1'b0;
      step(); chk("laf_to_da", V_DA);
      parity_done = 1'b0;

      // Soft reset while waiting: wrong port ignored, own port aborts.
      d_in = 2'd1; pkt_valid = 1'b1; fifo_empty_1 = 1'b0;
      step(); chk("sr_wte", V_WTE);
      soft_rst_0 = 1'b1;
      step(); chk("sr0_ignored", V_WTE);
      soft_rst_0 = 1'b0; soft_rst_1 = 1'b1; pkt_valid = 1'b0;
      step(); chk("sr1_abort", V_DA);
      soft_rst_1 = 1'b0; fifo_empty_1 = 1'b1;
      step(); chk("sr1_idle", V_DA);

      // Packet to FIFO2 with the FIFO filling during parity check.
      d_in = 2'd2; pkt_valid = 1'b1; fifo_empty_2 = 1'b1;
      step(); chk("p2_lfd", V_LFD);
      pkt_valid = 1'b0;
      step(); chk("p2_ld", V_LD);
      step(); chk("p2_lp", V_LP);
      fifo_full = 1'b1;
      step(); chk("p2_cpe", V_CPE);
      step(); chk("cpe_to_ffs", V_FFS);
      fifo_full = 1'b0;
      step(); chk("p2_laf", V_LAF);
      parity_done = 1'b1;
      step(); chk("p2_da", V_DA);
      parity_done = 1'b0;

      // Soft reset of FIFO2 mid-payload.
      d_in = 2'd2; pkt_valid = 1'b1;
      step(); chk("p2b_lfd", V_LFD);
      step(); chk("p2b_ld", V_LD);
      soft_rst_2 = 1'b1; pkt_valid = 1'b0;
      step(); chk("sr2_abort", V_DA);
      soft_rst_2 = 1'b0;

      // Invalid address 3 never leaves decode.
      d_in = 2'd3; pkt_valid = 1'b1;
      step(); chk("inv_1", V_DA);
      step(); chk("inv_2", V_DA);
      step(); chk("inv_3", V_DA);

      // Hard reset mid-packet.
      d_in = 2'd0; fifo_empty_0 = 1'b1;
      step(); chk("hr_lfd", V_LFD);
      step(); chk("hr_ld", V_LD);
      rst = 1'b1;
      step(); chk("hr_abort", V_DA);
      rst = 1'b0; pkt_valid = 1'b0;
      step(); chk("hr_idle", V_DA);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
